// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: PCSrc encodings,
// interrupt vector and the controller state type.
package pipe_pkg;

   localparam logic [2:0] PC_SEQ    = 3'b000;
   localparam logic [2:0] PC_BRANCH = 3'b001;
   localparam logic [2:0] PC_JUMP   = 3'b010;
   localparam logic [2:0] PC_JR     = 3'b011;
   localparam logic [2:0] PC_ILLOP  = 3'b100;
   localparam logic [2:0] PC_XADR   = 3'b101;

   localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      IRQ_BUSY = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (en && (q != '1))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: resolves load-use, branch/jump, memory-wait and
// interrupt admission into per-stage write-enables and flushes.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter bit BR_IN_EX = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [2:0]       id_pcsrc,
   input  logic             ex_memrd,
   input  logic [4:0]       ex_rt,
   input  logic             ex_br_taken,
   input  logic             mem_busy,
   input  logic             irq,
   input  logic             irq_clr,
   output logic             pc_wr,
   output logic             if_id_wr,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_wr,
   output logic             pc_irq_sel,
   output logic             irq_ack,
   output logic [CNT_W-1:0] stall_cycles
);

   hazard_state_t state;
   logic          in_handler;
   logic          load_use;
   logic          jump_id;
   logic          br_ex;
   logic          irq_take;

   always_comb begin
      load_use = ex_memrd && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      jump_id  = (id_pcsrc == PC_JUMP) || (id_pcsrc == PC_JR) ||
                 (id_pcsrc == PC_ILLOP) || (id_pcsrc == PC_XADR);
      br_ex    = BR_IN_EX && ex_br_taken;
      irq_take = irq && (state == RUN) && !mem_busy && !br_ex && !load_use && !jump_id;
   end

   // Priority: reset, memory wait, EX branch squash, load-use bubble, ID jump, interrupt.
   always_comb begin
      pc_wr       = 1'b1;
      if_id_wr    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_wr   = 1'b1;
      pc_irq_sel  = 1'b0;
      irq_ack     = 1'b0;
      if (reset) begin
         pc_wr       = 1'b0;
         if_id_wr    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         ex_mem_wr   = 1'b0;
      end else if (mem_busy) begin
         pc_wr     = 1'b0;
         if_id_wr  = 1'b0;
         ex_mem_wr = 1'b0;
      end else if (br_ex) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_wr       = 1'b0;
         if_id_wr    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (jump_id) begin
         if_id_flush = 1'b1;
      end else if (irq_take) begin
         if_id_flush = 1'b1;
         pc_irq_sel  = 1'b1;
         irq_ack     = 1'b1;
      end
   end

   // in_handler survives a memory wait so the interrupt mask is not lost in MEM_WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         in_handler <= 1'b0;
      end else begin
         if (irq_take)
            in_handler <= 1'b1;
         else if (irq_clr)
            in_handler <= 1'b0;

         if (mem_busy)
            state <= MEM_WAIT;
         else if (irq_take || (in_handler && !irq_clr))
            state <= IRQ_BUSY;
         else
            state <= RUN;
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .en  (!pc_wr && !reset),
      .clr (reset),
      .q   (stall_cycles)
   );

endmodule
